fv_core_if_mp_queue: RTL and testbench

//  Parametrised multi-port in-order instruction queue between the FV fetch model and the issue side.

---
 rtl/fv_if_queue_pkg.sv | 37 +++
 rtl/fv_core_if_mp_queue_if.sv | 37 +++
 rtl/fv_if_push_compactor.sv | 31 +++
 rtl/fv_core_if_mp_queue.sv | 141 ++++++++++++++
 tb/tb_fv_core_if_mp_queue.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fv_if_queue_pkg.sv
// Shared types, default sizing and mask helpers for the FV fetch-to-issue instruction queue.
package fv_if_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_queue_entry_t;

  localparam int DEF_ENTRY_W = $bits(if_queue_entry_t);
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_PUSH_N  = 2;
  localparam int DEF_POP_N   = 2;
  localparam int DEF_BYPASS  = 1;

  // Widest push/pop mask the helpers below accept; narrower masks are zero-extended.
  localparam int MASK_MAX = 8;

  function automatic logic [3:0] popcount(input logic [MASK_MAX-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MASK_MAX; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] lead_ones(input logic [MASK_MAX-1:0] v);
    logic [3:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < MASK_MAX; i++) begin
      if (run && v[i]) n = n + 4'd1;
      else             run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/fv_core_if_mp_queue_if.sv
// Handshake/status bundle between the fetch model (master) and the instruction queue (slave).
interface fv_core_if_mp_queue_if
  import fv_if_queue_pkg::*;
#(
  parameter int ENTRY_W = DEF_ENTRY_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PUSH_N  = DEF_PUSH_N,
  parameter int POP_N   = DEF_POP_N
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      stall;
  logic                      kill;
  logic                      kill_keep_push;
  logic [PUSH_N-1:0]         push_vld;
  logic [PUSH_N*ENTRY_W-1:0] push_data;
  logic                      push_rdy;
  logic [POP_N-1:0]          head_vld;
  logic [POP_N*ENTRY_W-1:0]  head_data;
  logic [POP_N-1:0]          pop;
  logic [CNT_W-1:0]          count;
  logic                      empty;
  logic                      full;
  logic                      err_ovf;
  logic                      err_pop;

  modport slave (
    input  stall, kill, kill_keep_push, push_vld, push_data, pop,
    output push_rdy, head_vld, head_data, count, empty, full, err_ovf, err_pop
  );

  modport master (
    output stall, kill, kill_keep_push, push_vld, push_data, pop,
    input  push_rdy, head_vld, head_data, count, empty, full, err_ovf, err_pop
  );

endinterface

// File: rtl/fv_if_push_compactor.sv
// Packs a sparse push mask into a dense, port-ordered entry list plus its length.
module fv_if_push_compactor
  import fv_if_queue_pkg::*;
#(
  parameter int ENTRY_W = DEF_ENTRY_W,
  parameter int PUSH_N  = DEF_PUSH_N,
  parameter int CNT_W   = 5
) (
  input  logic [PUSH_N-1:0]         vld_i,
  input  logic [PUSH_N*ENTRY_W-1:0] data_i,
  output logic [PUSH_N*ENTRY_W-1:0] dense_o,
  output logic [CNT_W-1:0]          n_o
);

  int slot;

  // Walk ports oldest-first, dropping each valid payload into the next free dense slot.
  always_comb begin
    dense_o = '0;
    slot    = 0;
    for (int i = 0; i < PUSH_N; i++) begin
      if (vld_i[i]) begin
        dense_o[slot*ENTRY_W +: ENTRY_W] = data_i[i*ENTRY_W +: ENTRY_W];
        slot = slot + 1;
      end
    end
  end

  assign n_o = CNT_W'(popcount(MASK_MAX'(vld_i)));

endmodule

// File: rtl/fv_core_if_mp_queue.sv
// Multi-port in-order instruction queue: circular storage, head mux with optional
// same-cycle bypass, pop legality checking, flush with optional push retention.
module fv_core_if_mp_queue
  import fv_if_queue_pkg::*;
#(
  parameter int ENTRY_W = DEF_ENTRY_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PUSH_N  = DEF_PUSH_N,
  parameter int POP_N   = DEF_POP_N,
  parameter int BYPASS  = DEF_BYPASS
) (
  input logic                  clk,
  input logic                  reset,
  fv_core_if_mp_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      ovf_q, ovf_d, perr_q, perr_d;
  logic                      push_rdy, pop_legal;
  logic [PUSH_N-1:0]         acc_vld, wr_en;
  logic [PTR_W-1:0]          wr_ptr [PUSH_N];
  logic [PUSH_N*ENTRY_W-1:0] dense;
  logic [CNT_W-1:0]          n_push, n_pop, n_take;
  logic [POP_N-1:0]          head_vld, pop_therm;

  // Credit comes from the registered count only, so a same-cycle pop never frees room.
  assign push_rdy = !q.stall && !reset && (count_q <= CNT_W'(DEPTH - PUSH_N));
  assign acc_vld  = q.push_vld & {PUSH_N{push_rdy}};

  fv_if_push_compactor #(
    .ENTRY_W (ENTRY_W),
    .PUSH_N  (PUSH_N),
    .CNT_W   (CNT_W)
  ) u_compactor (
    .vld_i   (acc_vld),
    .data_i  (q.push_data),
    .dense_o (dense),
    .n_o     (n_push)
  );

  // Head slots show stored entries first, then (bypass) this cycle's compacted pushes.
  always_comb begin
    head_vld    = '0;
    q.head_data = '0;
    for (int i = 0; i < POP_N; i++) begin
      if (i < int'(count_q)) begin
        head_vld[i] = 1'b1;
        q.head_data[i*ENTRY_W +: ENTRY_W] = mem_q[head_q + PTR_W'(i)];
      end else if (BYPASS != 0 && !q.stall && (i - int'(count_q)) < int'(n_push)) begin
        head_vld[i] = 1'b1;
        q.head_data[i*ENTRY_W +: ENTRY_W] = dense[(i - int'(count_q))*ENTRY_W +: ENTRY_W];
      end
    end
    if (q.kill) head_vld = '0;
  end

  // A pop is legal only as a thermometer from slot 0 that stays within the valid heads.
  always_comb begin
    n_pop = CNT_W'(lead_ones(MASK_MAX'(q.pop)));
    for (int i = 0; i < POP_N; i++) pop_therm[i] = (i < int'(n_pop));
    pop_legal = (q.pop == pop_therm) && ((q.pop & ~head_vld) == '0);
    n_take    = (pop_legal && !q.stall && !q.kill) ? n_pop : '0;
  end

  // Pointer/count/error next state and storage write enables.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q | ((|q.push_vld) && !push_rdy);
    perr_d  = perr_q | !pop_legal;
    wr_en   = '0;
    for (int j = 0; j < PUSH_N; j++) wr_ptr[j] = '0;
    if (q.kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (q.kill_keep_push && !q.stall) begin
        tail_d  = PTR_W'(n_push);
        count_d = n_push;
        for (int j = 0; j < PUSH_N; j++) begin
          wr_en[j]  = (j < int'(n_push));
          wr_ptr[j] = PTR_W'(j);
        end
      end
    end else if (!q.stall) begin
      head_d  = head_q + PTR_W'(n_take);
      tail_d  = tail_q + PTR_W'(n_push);
      count_d = count_q + n_push - n_take;
      // Bypassed entries consumed this cycle are skipped; only survivors land in storage.
      for (int j = 0; j < PUSH_N; j++) begin
        wr_en[j]  = (j < int'(n_push)) && ((int'(count_q) + j) >= int'(n_take));
        wr_ptr[j] = tail_q + PTR_W'(j);
      end
    end
  end

  // State register; reset wins over kill, stall and everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  // Entry storage; no reset needed since validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    for (int j = 0; j < PUSH_N; j++) begin
      if (!reset && wr_en[j]) mem_q[wr_ptr[j]] <= dense[j*ENTRY_W +: ENTRY_W];
    end
  end

  assign q.push_rdy = push_rdy;
  assign q.head_vld = head_vld;
  assign q.count    = count_q;
  assign q.empty    = (count_q == '0);
  assign q.full     = (count_q == CNT_W'(DEPTH));
  assign q.err_ovf  = ovf_q;
  assign q.err_pop  = perr_q;

`ifdef FV_ENABLE_SC_DEBUG
  a_no_ovf: assert property (@(posedge clk) disable iff (reset) !((|q.push_vld) && !push_rdy))
    else $error("push while push_rdy low");
  a_pop_legal: assert property (@(posedge clk) disable iff (reset) pop_legal)
    else $error("illegal pop pattern");
`endif

endmodule

// File: tb/tb_fv_core_if_mp_queue.sv
// Bench for the instruction queue: directed scenarios plus a randomized run against a
// queue-of-entries reference model.
module tb_fv_core_if_mp_queue;
  import fv_if_queue_pkg::*;

  localparam int ENTRY_W = 64;
  localparam int DEPTH   = 8;
  localparam int PUSH_N  = 2;
  localparam int POP_N   = 2;
  localparam int BYPASS  = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fv_core_if_mp_queue_if #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .PUSH_N(PUSH_N), .POP_N(POP_N)) qif ();

  fv_core_if_mp_queue #(
    .ENTRY_W (ENTRY_W), .DEPTH (DEPTH), .PUSH_N (PUSH_N), .POP_N (POP_N), .BYPASS (BYPASS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the queue contents as a plain list, oldest first.
  logic [63:0] mq[$];
  logic [63:0] acc[$];
  bit          m_ovf, m_perr;

  bit          s_stall, s_kill, s_keep;
  logic [1:0]  s_vld, s_pop;
  logic [63:0] s_d[2];

  bit          e_rdy, e_legal;
  logic [1:0]  e_hvld;
  logic [63:0] e_hd[2];
  int          e_take, e_nvalid;

  task automatic model_eval();
    int npop;
    int sz;
    sz    = mq.size();
    e_rdy = !s_stall && !reset && ((DEPTH - sz) >= PUSH_N);
    acc.delete();
    for (int i = 0; i < PUSH_N; i++) if (s_vld[i] && e_rdy) acc.push_back(s_d[i]);
    e_nvalid = 0;
    for (int i = 0; i < POP_N; i++) begin
      e_hvld[i] = 1'b0;
      e_hd[i]   = '0;
      if (!s_kill) begin
        if (i < sz) begin
          e_hvld[i] = 1'b1; e_hd[i] = mq[i];
        end else if (BYPASS != 0 && !s_stall && (i - sz) < acc.size()) begin
          e_hvld[i] = 1'b1; e_hd[i] = acc[i - sz];
        end
      end
      if (e_hvld[i]) e_nvalid++;
    end
    npop = 0;
    while (npop < POP_N && s_pop[npop]) npop++;
    e_legal = ((s_pop >> npop) == 0) && (npop <= e_nvalid);
    e_take  = (e_legal && !s_stall && !s_kill) ? npop : 0;
  endtask

  task automatic model_commit();
    if (reset) begin
      mq.delete(); m_ovf = 0; m_perr = 0;
      return;
    end
    if (s_vld != 0 && !e_rdy) m_ovf = 1;
    if (!e_legal) m_perr = 1;
    if (s_kill) begin
      mq.delete();
      if (s_keep && !s_stall) mq = acc;
    end else if (!s_stall) begin
      foreach (acc[i]) mq.push_back(acc[i]);
      repeat (e_take) void'(mq.pop_front());
    end
  endtask

  task automatic drive(input bit st, input bit k, input bit kp, input logic [1:0] v,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] p);
    s_stall = st; s_kill = k; s_keep = kp; s_vld = v; s_d[0] = d0; s_d[1] = d1; s_pop = p;
    qif.stall = st; qif.kill = k; qif.kill_keep_push = kp; qif.push_vld = v;
    qif.push_data = {d1, d0}; qif.pop = p;
    #1;
    model_eval();
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, '0, '0, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 2'b11, 64'h11, 64'h22, 2'b00);
    n_tests++; if (qif.push_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_rdy_during got=%0b exp=0", qif.push_rdy); end
    tick();
    reset = 1'b0;
    idle();
    n_tests++; if (qif.count !== 4'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", qif.count); end
    n_tests++; if (qif.empty !== 1'b1 || qif.full !== 1'b0) begin n_fail++; $display("FAIL rst_empty_full got=%0b%0b exp=10", qif.empty, qif.full); end
    n_tests++; if (qif.head_vld !== 2'b00) begin n_fail++; $display("FAIL rst_head_vld got=%0b exp=00", qif.head_vld); end
    n_tests++; if (qif.push_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_push_rdy got=%0b exp=1", qif.push_rdy); end
    n_tests++; if (qif.err_ovf !== 1'b0 || qif.err_pop !== 1'b0) begin n_fail++; $display("FAIL rst_errs got=%0b%0b exp=00", qif.err_ovf, qif.err_pop); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(0, 0, 0, 2'b11, 64'hA, 64'hB, 2'b00);
    n_tests++; if (qif.count !== 4'd0) begin n_fail++; $display("FAIL t1_count0 got=%0d exp=0", qif.count); end
    tick();
    drive(0, 0, 0, 2'b01, 64'hC, 64'h0, 2'b00);
    n_tests++; if (qif.count !== 4'd2) begin n_fail++; $display("FAIL t1_count2 got=%0d exp=2", qif.count); end
    n_tests++; if (qif.head_vld !== 2'b11 || qif.head_data !== {64'hB, 64'hA}) begin n_fail++; $display("FAIL t1_head_ab got=%0b/%h exp=11/B,A", qif.head_vld, qif.head_data); end
    tick();
    drive(0, 0, 0, 2'b00, '0, '0, 2'b11);
    n_tests++; if (qif.count !== 4'd3) begin n_fail++; $display("FAIL t1_count3 got=%0d exp=3", qif.count); end
    tick();
    idle();
    n_tests++; if (qif.count !== 4'd1) begin n_fail++; $display("FAIL t1_count1 got=%0d exp=1", qif.count); end
    n_tests++; if (qif.head_vld !== 2'b01 || qif.head_data[63:0] !== 64'hC) begin n_fail++; $display("FAIL t1_head_c got=%0b/%h exp=01/C", qif.head_vld, qif.head_data[63:0]); end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(0, 0, 0, 2'b10, 64'h0, 64'hD, 2'b01);
    n_tests++; if (qif.head_vld !== 2'b01 || qif.head_data[63:0] !== 64'hD) begin n_fail++; $display("FAIL t2_bypass got=%0b/%h exp=01/D", qif.head_vld, qif.head_data[63:0]); end
    tick();
    idle();
    n_tests++; if (qif.count !== 4'd0 || qif.empty !== 1'b1) begin n_fail++; $display("FAIL t2_empty got=%0d/%0b exp=0/1", qif.count, qif.empty); end
    n_tests++; if (qif.err_pop !== 1'b0) begin n_fail++; $display("FAIL t2_no_err got=%0b exp=0", qif.err_pop); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 2'b11, 64'(2*i), 64'(2*i+1), 2'b00); tick(); end
    drive(0, 0, 0, 2'b01, 64'h6, 64'h0, 2'b00); tick();
    drive(0, 0, 0, 2'b11, 64'h77, 64'h88, 2'b00);
    n_tests++; if (qif.push_rdy !== 1'b0) begin n_fail++; $display("FAIL t3_rdy_low got=%0b exp=0", qif.push_rdy); end
    tick();
    idle();
    n_tests++; if (qif.err_ovf !== 1'b1 || qif.count !== 4'd7) begin n_fail++; $display("FAIL t3_ovf got=%0b/%0d exp=1/7", qif.err_ovf, qif.count); end
    drive(0, 0, 0, 2'b00, '0, '0, 2'b11); tick();
    idle();
    n_tests++; if (qif.count !== 4'd5 || qif.push_rdy !== 1'b1) begin n_fail++; $display("FAIL t3_after_pop got=%0d/%0b exp=5/1", qif.count, qif.push_rdy); end
  endtask

  task automatic test_wrap();
    int seq = 0;
    int pseq = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 2'b11, 64'(seq), 64'(seq+1), 2'b00); tick(); seq += 2; end
    for (int it = 0; it < 12; it++) begin
      drive(0, 0, 0, 2'b00, '0, '0, 2'b11);
      n_tests++;
      if (qif.head_vld !== 2'b11 || qif.head_data !== {64'(pseq+1), 64'(pseq)}) begin
        n_fail++; $display("FAIL t4_order it=%0d got=%0b/%h exp=11/%0d,%0d", it, qif.head_vld, qif.head_data, pseq+1, pseq);
      end
      tick(); pseq += 2;
      drive(0, 0, 0, 2'b11, 64'(seq), 64'(seq+1), 2'b00); tick(); seq += 2;
    end
    idle();
    n_tests++; if (qif.count !== 4'd8 || qif.full !== 1'b1) begin n_fail++; $display("FAIL t4_full got=%0d/%0b exp=8/1", qif.count, qif.full); end
  endtask

  task automatic test_kill();
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 2'b11, 64'(i), 64'(i+8), 2'b00); tick(); end
    drive(0, 1, 1, 2'b11, 64'hE, 64'hF, 2'b00);
    n_tests++; if (qif.head_vld !== 2'b00) begin n_fail++; $display("FAIL t5_kill_hvld got=%0b exp=00", qif.head_vld); end
    tick();
    idle();
    n_tests++; if (qif.count !== 4'd2 || qif.head_vld !== 2'b11 || qif.head_data !== {64'hF, 64'hE}) begin n_fail++; $display("FAIL t5_keep got=%0d/%0b/%h exp=2/11/F,E", qif.count, qif.head_vld, qif.head_data); end
    drive(0, 0, 0, 2'b11, 64'h10, 64'h11, 2'b00); tick();
    drive(0, 1, 0, 2'b11, 64'h12, 64'h13, 2'b00); tick();
    idle();
    n_tests++; if (qif.count !== 4'd0 || qif.empty !== 1'b1) begin n_fail++; $display("FAIL t5_nokeep got=%0d/%0b exp=0/1", qif.count, qif.empty); end
  endtask

  task automatic test_errors_stall();
    drive(0, 0, 0, 2'b11, 64'h51, 64'h52, 2'b00); tick();
    drive(0, 0, 0, 2'b00, '0, '0, 2'b10); tick();
    idle();
    n_tests++; if (qif.err_pop !== 1'b1 || qif.count !== 4'd2) begin n_fail++; $display("FAIL t6_errpop got=%0b/%0d exp=1/2", qif.err_pop, qif.count); end
    drive(1, 0, 0, 2'b11, 64'h61, 64'h62, 2'b11);
    n_tests++; if (qif.push_rdy !== 1'b0 || qif.head_vld !== 2'b11) begin n_fail++; $display("FAIL t6_stall_out got=%0b/%0b exp=0/11", qif.push_rdy, qif.head_vld); end
    tick();
    idle();
    n_tests++; if (qif.count !== 4'd2 || qif.head_data !== {64'h52, 64'h51}) begin n_fail++; $display("FAIL t6_stall_hold got=%0d/%h exp=2/52,51", qif.count, qif.head_data); end
    reset = 1'b1;
    drive(0, 1, 1, 2'b11, 64'h71, 64'h72, 2'b00); tick();
    reset = 1'b0;
    idle();
    n_tests++; if (qif.count !== 4'd0 || qif.head_vld !== 2'b00 || qif.empty !== 1'b1) begin n_fail++; $display("FAIL t6_rst_kill got=%0d/%0b/%0b exp=0/00/1", qif.count, qif.head_vld, qif.empty); end
    n_tests++; if (qif.err_ovf !== 1'b0 || qif.err_pop !== 1'b0) begin n_fail++; $display("FAIL t6_rst_errs got=%0b%0b exp=00", qif.err_ovf, qif.err_pop); end
  endtask

  task automatic test_random();
    bit st, k, kp;
    logic [1:0] v, p;
    logic [63:0] d0, d1;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 80 == 79) do_reset();
      st = ($urandom_range(0, 9) == 0);
      k  = ($urandom_range(0, 15) == 0);
      kp = 1'($urandom_range(0, 1));
      v  = 2'($urandom_range(0, 3));
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      drive(st, k, kp, v, d0, d1, 2'b00);
      if ($urandom_range(0, 19) == 0) p = 2'($urandom_range(0, 3));
      else p = 2'((1 << $urandom_range(0, e_nvalid)) - 1);
      drive(st, k, kp, v, d0, d1, p);
      n_tests++; if (qif.push_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy cyc=%0d got=%0b exp=%0b", cyc, qif.push_rdy, e_rdy); end
      n_tests++; if (qif.head_vld !== e_hvld) begin n_fail++; $display("FAIL rnd_hvld cyc=%0d got=%0b exp=%0b", cyc, qif.head_vld, e_hvld); end
      for (int i = 0; i < POP_N; i++) begin
        if (e_hvld[i]) begin
          n_tests++; if (qif.head_data[i*64 +: 64] !== e_hd[i]) begin n_fail++; $display("FAIL rnd_hdata cyc=%0d slot=%0d got=%h exp=%h", cyc, i, qif.head_data[i*64 +: 64], e_hd[i]); end
        end
      end
      n_tests++; if (qif.count !== 4'(mq.size()) || qif.empty !== (mq.size() == 0) || qif.full !== (mq.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d/%0b%0b exp=%0d", cyc, qif.count, qif.empty, qif.full, mq.size());
      end
      n_tests++; if (qif.err_ovf !== m_ovf || qif.err_pop !== m_perr) begin n_fail++; $display("FAIL rnd_errs cyc=%0d got=%0b%0b exp=%0b%0b", cyc, qif.err_ovf, qif.err_pop, m_ovf, m_perr); end
      tick();
    end
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_wrap();
    test_kill();
    test_errors_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
